fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_seq_pkg.sv | 23 ++
 rtl/fetch_sequencer_ret_stack.sv | 56 +++++
 rtl/fetch_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// ============================================================================
// Module   : fetch_seq_pkg
// Purpose  : Shared FSM state type and default sizing for fetch_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_seq_pkg;

  localparam int unsigned c_PC_WIDTH    = 8;
  localparam logic [7:0]  c_RESET_PC    = 8'h00;
  localparam int unsigned c_STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_ret_stack.sv
// ============================================================================
// Module   : ret_stack
// Purpose  : LIFO of return addresses; callers must not push when full or
//            pop when empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_CNT_W-1:0] r_count;
  logic [c_IDX_W-1:0] w_wr_idx;
  logic [c_IDX_W-1:0] w_top_idx;

  assign w_wr_idx  = c_IDX_W'(r_count);
  assign w_top_idx = c_IDX_W'(r_count - c_CNT_W'(1));
  assign o_full    = (r_count == c_CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[w_top_idx];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_count <= r_count + c_CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - c_CNT_W'(1);
    end
  end

  // Storage needs no reset: an empty count makes every entry stale.
  always_ff @(posedge clk) begin
    if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction fetch/execute sequencer with branch, jump and halt.
//            Define FETCH_SEQ_CALL_STACK_EN to enable the call/return stack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = c_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = PC_WIDTH'(c_RESET_PC)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [7:0]          imem_data,
  output logic [7:0]          instr,
  output logic                instr_valid,
  input  logic                ex_done,
  input  logic                PCSrc,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] offset,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                halt,
  input  logic                call,
  input  logic                ret,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                stack_err
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [7:0]          r_instr;
  logic                r_instr_valid;
  logic                w_capture;
  logic                w_push;
  logic                w_pop;
  logic                w_err_set;
  logic                w_call_en;
  logic                w_ret_en;
  logic                w_stk_full;
  logic                w_stk_empty;
  logic [PC_WIDTH-1:0] w_stk_data;

`ifdef FETCH_SEQ_CALL_STACK_EN
  logic r_stack_err;

  assign w_call_en = call;
  assign w_ret_en  = ret;
  assign stack_err = r_stack_err;

  ret_stack #(
    .DEPTH (c_STACK_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ret_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_data  (w_stk_data),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stack_err <= 1'b0;
    end else if (w_err_set) begin
      r_stack_err <= 1'b1;
    end
  end
`else
  logic w_unused;

  assign w_call_en   = 1'b0;
  assign w_ret_en    = 1'b0;
  assign w_stk_full  = 1'b0;
  assign w_stk_empty = 1'b1;
  assign w_stk_data  = '0;
  assign stack_err   = 1'b0;
  assign w_unused    = ^{call, ret, w_push, w_pop, w_err_set};
`endif

  assign w_pc_inc    = r_pc + PC_WIDTH'(1);
  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign imem_req    = (r_state == S_FETCH);
  assign halted      = (r_state == S_HALTED);
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr_valid <= w_capture;
      if (w_capture) begin
        r_instr <= imem_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ex_done) begin
          w_state_nxt = S_FETCH;
          if (halt) begin
            w_state_nxt = S_HALTED;
          end else if (w_ret_en) begin
            // Return with nothing stacked falls through as sequential.
            if (w_stk_empty) begin
              w_pc_nxt  = w_pc_inc;
              w_err_set = 1'b1;
            end else begin
              w_pop    = 1'b1;
              w_pc_nxt = w_stk_data;
            end
          end else if (w_call_en) begin
            w_pc_nxt = jump_target;
            if (w_stk_full) begin
              w_err_set = 1'b1;
            end else begin
              w_push = 1'b1;
            end
          end else if (jump) begin
            w_pc_nxt = jump_target;
          end else if (PCSrc) begin
            w_pc_nxt = w_pc_inc + offset;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end
      default: begin
        w_state_nxt = S_HALTED;
      end
    endcase
  end

endmodule

`default_nettype wire
